// File: rtl/ibc_cache_sched.sv
// ibc_cache_sched: shares one IBC reference-cache port between CTU write-backs and reference reads.
// Define IBC_SCHED_FAIR_EN to force a write-back grant after MAX_REQ_BURST reads while one is waiting.
module ibc_cache_sched #(
    parameter int BLOCK_SIZE     = 8,
    parameter int CTU_SIZE       = 64,
    parameter int IMG_WIDTH      = 1920,
    parameter int IMG_HEIGHT     = 1080,
    parameter int COORD_WIDTH    = 13,
    parameter int REQ_FILE_WIDTH = 32,
    parameter int WB_DATA_WIDTH  = 536,
    parameter int MAX_REQ_BURST  = 4,
    localparam int CTU_COLS      = (IMG_WIDTH + CTU_SIZE - 1) / CTU_SIZE,
    localparam int CTU_ROWS      = (IMG_HEIGHT + CTU_SIZE - 1) / CTU_SIZE,
    localparam int TOTAL_CTUS    = CTU_COLS * CTU_ROWS,
    localparam int CIDX_W        = $clog2(TOTAL_CTUS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_valid_in,
    input  logic                          wb_ctu_last_in,
    input  logic [WB_DATA_WIDTH-1:0]      wb_data_in,
    output logic                          wb_ready_out,
    input  logic                          req_valid_in,
    input  logic signed [COORD_WIDTH-1:0] req_x_in,
    input  logic signed [COORD_WIDTH-1:0] req_y_in,
    output logic                          req_ready_out,
    output logic                          cache_wb_en_out,
    output logic [WB_DATA_WIDTH-1:0]      cache_wb_data_out,
    input  logic                          cache_wb_ack_in,
    output logic                          cache_req_valid_out,
    output logic [2*REQ_FILE_WIDTH-1:0]   cache_req_data_out,
    input  logic                          cache_req_ready_in,
    output logic [CIDX_W-1:0]             ctus_done_out,
    output logic [15:0]                   stall_cnt_out
);
    localparam logic [CIDX_W-1:0] TOTAL_C = CIDX_W'(TOTAL_CTUS);

    typedef enum logic [1:0] {ARB, REQ, WB} state_t;
    state_t state_q, state_d;

    logic [CIDX_W-1:0]           ctus_done_q, ctus_done_d;
    logic                        pic_done_q, pic_done_d;
    logic [15:0]                 stall_q, stall_d;
    logic [2*REQ_FILE_WIDTH-1:0] req_data_q, req_data_d;
    logic [WB_DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
    logic                        wb_last_q, wb_last_d;

    logic [COORD_WIDTH-1:0] x_pos, y_pos;
    logic [31:0]            cx_ext, cy_ext, cx, cy, idx;
    logic                   eligible, force_wb, grant_req, grant_wb;

    // The bottom-right pixel of the clamped block lands in the highest-index CTU it touches.
    assign x_pos = req_x_in[COORD_WIDTH-1] ? '0 : $unsigned(req_x_in);
    assign y_pos = req_y_in[COORD_WIDTH-1] ? '0 : $unsigned(req_y_in);

    always_comb begin
        cx_ext   = 32'(x_pos) + 32'(BLOCK_SIZE - 1);
        cy_ext   = 32'(y_pos) + 32'(BLOCK_SIZE - 1);
        cx       = (cx_ext > 32'(IMG_WIDTH - 1))  ? 32'(IMG_WIDTH - 1)  : cx_ext;
        cy       = (cy_ext > 32'(IMG_HEIGHT - 1)) ? 32'(IMG_HEIGHT - 1) : cy_ext;
        idx      = (cy / 32'(CTU_SIZE)) * 32'(CTU_COLS) + cx / 32'(CTU_SIZE);
        eligible = idx < 32'(ctus_done_q);
    end

`ifdef IBC_SCHED_FAIR_EN
    localparam int BURST_W = $clog2(MAX_REQ_BURST + 1);
    logic [BURST_W-1:0] burst_q, burst_d;

    assign force_wb = wb_valid_in && (burst_q == BURST_W'(MAX_REQ_BURST));

    always_comb begin
        burst_d = burst_q;
        if (grant_wb)
            burst_d = '0;
        else if (grant_req && wb_valid_in)
            burst_d = burst_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            burst_q <= '0;
        else
            burst_q <= burst_d;
    end
`else
    assign force_wb = 1'b0;
`endif

    assign grant_req = !reset && (state_q == ARB) && req_valid_in && eligible && !force_wb;
    assign grant_wb  = !reset && (state_q == ARB) && wb_valid_in && !grant_req;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ARB;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: begin
                if (grant_req)
                    state_d = REQ;
                else if (grant_wb)
                    state_d = WB;
            end
            REQ:     if (cache_req_ready_in) state_d = ARB;
            WB:      if (cache_wb_ack_in) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        wb_ready_out        = grant_wb;
        req_ready_out       = grant_req;
        cache_wb_en_out     = (state_q == WB);
        cache_req_valid_out = (state_q == REQ);
        cache_wb_data_out   = wb_data_q;
        cache_req_data_out  = req_data_q;
        ctus_done_out       = ctus_done_q;
        stall_cnt_out       = stall_q;
    end

    always_comb begin
        ctus_done_d = ctus_done_q;
        pic_done_d  = pic_done_q;
        stall_d     = stall_q;
        req_data_d  = req_data_q;
        wb_data_d   = wb_data_q;
        wb_last_d   = wb_last_q;
        if (grant_req)
            req_data_d = {{(REQ_FILE_WIDTH-COORD_WIDTH){req_y_in[COORD_WIDTH-1]}}, req_y_in,
                          {(REQ_FILE_WIDTH-COORD_WIDTH){req_x_in[COORD_WIDTH-1]}}, req_x_in};
        // First write-back of the next picture restarts progress tracking.
        if (grant_wb) begin
            wb_data_d = wb_data_in;
            wb_last_d = wb_ctu_last_in;
            if (pic_done_q) begin
                ctus_done_d = '0;
                pic_done_d  = 1'b0;
            end
        end
        if ((state_q == WB) && cache_wb_ack_in && wb_last_q && (ctus_done_q != TOTAL_C)) begin
            ctus_done_d = ctus_done_q + 1'b1;
            pic_done_d  = (ctus_done_d == TOTAL_C);
        end
        if ((state_q == ARB) && req_valid_in && !eligible && !grant_wb && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctus_done_q <= '0;
            pic_done_q  <= 1'b0;
            stall_q     <= '0;
            req_data_q  <= '0;
            wb_data_q   <= '0;
            wb_last_q   <= 1'b0;
        end else begin
            ctus_done_q <= ctus_done_d;
            pic_done_q  <= pic_done_d;
            stall_q     <= stall_d;
            req_data_q  <= req_data_d;
            wb_data_q   <= wb_data_d;
            wb_last_q   <= wb_last_d;
        end
    end
endmodule

// File: tb/tb_ibc_cache_sched.sv
// Self-checking bench for ibc_cache_sched: directed boundary cases plus randomized traffic
// checked against a CTU-coverage model of reference eligibility.
module tb_ibc_cache_sched;
    localparam int WBW    = 536;
    localparam int IMG_W  = 1920;
    localparam int IMG_H  = 1080;
    localparam int CTU    = 64;
    localparam int COLS   = 30;
    localparam int TOTAL  = 510;
    localparam int CIDX_W = 9;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    wb_valid_in, wb_ctu_last_in, wb_ready_out;
    logic [WBW-1:0]          wb_data_in;
    logic                    req_valid_in, req_ready_out;
    logic signed [12:0]      req_x_in, req_y_in;
    logic                    cache_wb_en_out, cache_wb_ack_in;
    logic [WBW-1:0]          cache_wb_data_out;
    logic                    cache_req_valid_out, cache_req_ready_in;
    logic [63:0]             cache_req_data_out;
    logic [CIDX_W-1:0]       ctus_done_out;
    logic [15:0]             stall_cnt_out;

    always #5 clk = ~clk;

    ibc_cache_sched dut (
        .clk(clk), .reset(reset),
        .wb_valid_in(wb_valid_in), .wb_ctu_last_in(wb_ctu_last_in), .wb_data_in(wb_data_in),
        .wb_ready_out(wb_ready_out),
        .req_valid_in(req_valid_in), .req_x_in(req_x_in), .req_y_in(req_y_in),
        .req_ready_out(req_ready_out),
        .cache_wb_en_out(cache_wb_en_out), .cache_wb_data_out(cache_wb_data_out),
        .cache_wb_ack_in(cache_wb_ack_in),
        .cache_req_valid_out(cache_req_valid_out), .cache_req_data_out(cache_req_data_out),
        .cache_req_ready_in(cache_req_ready_in),
        .ctus_done_out(ctus_done_out), .stall_cnt_out(stall_cnt_out)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int model_done = 0;
    bit model_pic = 0;
    int stall_exp = 0;
    int burst_exp = 0;
    int cur_x, cur_y;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Eligible when every CTU covered by the clamped block has been written.
    function automatic bit model_elig(input int x, input int y, input int done);
        int x0, y0, x1, y1, hi;
        x0 = (x < 0) ? 0 : x;
        y0 = (y < 0) ? 0 : y;
        x1 = (x0 + 7 > IMG_W - 1) ? IMG_W - 1 : x0 + 7;
        y1 = (y0 + 7 > IMG_H - 1) ? IMG_H - 1 : y0 + 7;
        if (x0 > x1) x0 = x1;
        if (y0 > y1) y0 = y1;
        hi = -1;
        for (int r = y0 / CTU; r <= y1 / CTU; r++)
            for (int c = x0 / CTU; c <= x1 / CTU; c++)
                if (r * COLS + c > hi) hi = r * COLS + c;
        return hi < done;
    endfunction

    task automatic do_wb(input bit last, input int delay);
        logic [WBW-1:0] d;
        int n;
        d = '0;
        for (int i = 0; i < 17; i++) d = {d[WBW-33:0], 32'($urandom)};
        wb_data_in = d;
        wb_ctu_last_in = last;
        wb_valid_in = 1'b1;
        settle;
        n = 0;
        while (!wb_ready_out && n < 50) begin
            tick;
            settle;
            n++;
        end
        chk("wb_grant", wb_ready_out, 1);
        if (model_pic) begin
            model_done = 0;
            model_pic = 0;
        end
        burst_exp = 0;
        tick;
        wb_valid_in = 1'b0;
        wb_data_in = '0;
        settle;
        chk("wb_done_at_grant", ctus_done_out, model_done);
        for (int i = 0; i < delay; i++) begin
            chk("wb_en_hold", cache_wb_en_out, 1);
            chk("wb_data_hold", cache_wb_data_out == d, 1);
            tick;
            settle;
        end
        cache_wb_ack_in = 1'b1;
        chk("wb_en", cache_wb_en_out, 1);
        chk("wb_data", cache_wb_data_out == d, 1);
        tick;
        cache_wb_ack_in = 1'b0;
        if (last && model_done < TOTAL) begin
            model_done++;
            if (model_done == TOTAL) model_pic = 1;
        end
        settle;
        chk("wb_en_drop", cache_wb_en_out, 0);
        chk("ctus_done", ctus_done_out, model_done);
    endtask

    task automatic req_start(input int x, input int y);
        cur_x = x;
        cur_y = y;
        req_x_in = 13'(x);
        req_y_in = 13'(y);
        req_valid_in = 1'b1;
    endtask

    task automatic req_block(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            settle;
            chk("req_blocked", req_ready_out, 0);
            tick;
            stall_exp++;
        end
    endtask

    task automatic req_finish(input int delay);
        logic [63:0] exp;
        int n;
        exp = {cur_y, cur_x};
        settle;
        n = 0;
        while (!req_ready_out && n < 20) begin
            tick;
            settle;
            n++;
        end
        chk("req_grant", req_ready_out, 1);
        chk("req_grant_wait", n, 0);
        tick;
        req_valid_in = 1'b0;
        settle;
        for (int i = 0; i < delay; i++) begin
            chk("req_valid_hold", cache_req_valid_out, 1);
            chk("req_data_hold", cache_req_data_out, exp);
            tick;
            settle;
        end
        cache_req_ready_in = 1'b1;
        chk("req_valid", cache_req_valid_out, 1);
        chk("req_data", cache_req_data_out, exp);
        tick;
        cache_req_ready_in = 1'b0;
        settle;
        chk("req_valid_drop", cache_req_valid_out, 0);
    endtask

    initial begin
        // Reset with every input driven high.
        reset = 1'b1;
        wb_valid_in = 1'b1; wb_ctu_last_in = 1'b1; wb_data_in = '1;
        req_valid_in = 1'b1; req_x_in = '1; req_y_in = '1;
        cache_wb_ack_in = 1'b1; cache_req_ready_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            settle;
            chk("rst_wb_ready", wb_ready_out, 0);
            chk("rst_req_ready", req_ready_out, 0);
            chk("rst_wb_en", cache_wb_en_out, 0);
            chk("rst_req_valid", cache_req_valid_out, 0);
            chk("rst_ctus_done", ctus_done_out, 0);
            chk("rst_stall", stall_cnt_out, 0);
            chk("rst_wb_data", |cache_wb_data_out, 0);
            chk("rst_req_data", cache_req_data_out, 0);
        end
        reset = 1'b0;
        wb_valid_in = 1'b0; wb_ctu_last_in = 1'b0; wb_data_in = '0;
        req_valid_in = 1'b0; req_x_in = '0; req_y_in = '0;
        cache_wb_ack_in = 1'b0; cache_req_ready_in = 1'b0;

        // Request at origin waits for CTU 0; write-backs proceed underneath it.
        req_start(0, 0);
        req_block(5);
        settle;
        chk("stall_cnt_initial", stall_cnt_out, stall_exp);
        for (int i = 0; i < 63; i++) do_wb(1'b0, 0);
        do_wb(1'b1, 0);
        chk("stall_cnt_after_wb", stall_cnt_out, stall_exp);
        req_finish(3);

        // Block reaching into CTU 1.
        req_start(60, 0);
        req_block(4);
        do_wb(1'b1, 0);
        req_finish(0);

        // Negative coordinates clamp to CTU 0 but are forwarded unclamped.
        req_start(-5, -3);
        req_finish(1);

        for (int it = 0; it < 30; it++) begin
            int x, y, guard;
            x = int'($urandom_range(1960, 0)) - 20;
            y = int'($urandom_range(320, 0)) - 20;
            req_start(x, y);
            if (!model_elig(x, y, model_done)) begin
                req_block(int'($urandom_range(3, 1)));
                guard = 0;
                while (!model_elig(x, y, model_done) && guard < 400) begin
                    do_wb(($urandom % 4) != 0, int'($urandom_range(2, 0)));
                    guard++;
                end
            end
            req_finish(int'($urandom_range(3, 0)));
        end
        settle;
        chk("stall_cnt_random", stall_cnt_out, stall_exp);

        // Bottom-right corner needs the whole picture.
        while (model_done < TOTAL - 1) do_wb(1'b1, 0);
        req_start(1915, 1075);
        req_block(3);
        do_wb(1'b1, 0);
        chk("pic_full", ctus_done_out, TOTAL);
        req_finish(0);
        do_wb(1'b1, 0);

        // Stray handshakes while idle change nothing.
        cache_wb_ack_in = 1'b1;
        cache_req_ready_in = 1'b1;
        tick;
        cache_wb_ack_in = 1'b0;
        cache_req_ready_in = 1'b0;
        settle;
        chk("stray_ctus_done", ctus_done_out, model_done);
        chk("stray_wb_en", cache_wb_en_out, 0);
        chk("stray_req_valid", cache_req_valid_out, 0);

        // Write-back and eligible reads both pending every arbitration cycle.
        wb_data_in = '0;
        wb_ctu_last_in = 1'b0;
        wb_valid_in = 1'b1;
        req_start(0, 0);
        for (int g = 0; g < 5; g++) begin
            bit exp_wb;
`ifdef IBC_SCHED_FAIR_EN
            exp_wb = (burst_exp == 4);
`else
            exp_wb = 1'b0;
`endif
            req_valid_in = 1'b1;
            settle;
            chk("b2b_wb_grant", wb_ready_out, exp_wb);
            chk("b2b_req_grant", req_ready_out, !exp_wb);
            if (wb_ready_out) begin
                burst_exp = 0;
                tick;
                wb_valid_in = 1'b0;
                cache_wb_ack_in = 1'b1;
                settle;
                chk("b2b_wb_en", cache_wb_en_out, 1);
                tick;
                cache_wb_ack_in = 1'b0;
            end else begin
                if (req_ready_out) burst_exp++;
                tick;
                req_valid_in = 1'b0;
                cache_req_ready_in = 1'b1;
                settle;
                chk("b2b_req_valid", cache_req_valid_out, 1);
                tick;
                cache_req_ready_in = 1'b0;
            end
        end
        if (req_valid_in) req_finish(0);
        do_wb(1'b0, 0);

        // Slow acknowledge, then reset while a write-back is outstanding.
        do_wb(1'b1, 10);
        wb_data_in = '1;
        wb_ctu_last_in = 1'b1;
        wb_valid_in = 1'b1;
        settle;
        chk("rstwait_grant", wb_ready_out, 1);
        tick;
        wb_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("rstwait_en", cache_wb_en_out, 1);
            tick;
        end
        reset = 1'b1;
        tick;
        settle;
        chk("rstwait_en_drop", cache_wb_en_out, 0);
        chk("rstwait_ctus_done", ctus_done_out, 0);
        chk("rstwait_stall", stall_cnt_out, 0);
        reset = 1'b0;
        model_done = 0;
        model_pic = 0;
        burst_exp = 0;
        stall_exp = 0;
        do_wb(1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
